// File: rtl/axil_cmd_pkg.sv
// ---------------------------------------------------------------------------
// axil_cmd_pkg
// Shared types and constants for axil_cmd_master.
//   cmd_state_e : FSM state encoding (DRAIN exists only when the optional
//                 watchdog, macro AXIL_CMD_TIMEOUT_EN, is compiled in)
//   RESP_*      : AXI response codes
// ---------------------------------------------------------------------------
package axil_cmd_pkg;

`ifdef AXIL_CMD_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5,
        DRAIN   = 3'd6
    } cmd_state_e;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } cmd_state_e;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_master.sv
// ---------------------------------------------------------------------------
// axil_cmd_master
// Single-outstanding AXI4-Lite initiator driven by a simple command/response
// port. A command is accepted in IDLE, turned into one AXI4-Lite read or write,
// and the BRESP/RRESP (plus read data) comes back on the response port.
//
// Optional feature: define AXIL_CMD_TIMEOUT_EN to add a watchdog that answers
// a stalled transaction with SLVERR/rsp_timeout and then drains the late AXI
// handshakes before returning to IDLE.
//
// Ports
//   aclk, areset             clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready is combinational)
//   cmd_we, cmd_addr,
//   cmd_wdata, cmd_wstrb     command payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_resp,
//   rsp_timeout              response payload (rdata is 0 for writes)
//   m_axi_*                  AXI4-Lite master channels (AW, W, B, AR, R)
// ---------------------------------------------------------------------------
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,
    // command port
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    // response port
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    // AXI4-Lite write address
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    // AXI4-Lite write data
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    // AXI4-Lite read address
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // AXI4-Lite read data
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    import axil_cmd_pkg::*;

    localparam int SW = DATA_WIDTH / 8;

    // Elaboration-time parameter sanity checks.
    if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64))) begin : g_bad_data_width
        $error("axil_cmd_master: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 2");
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    cmd_state_e              state_r,     state_nxt_s;
    logic                    awvalid_r,   awvalid_nxt_s;
    logic                    wvalid_r,    wvalid_nxt_s;
    logic                    arvalid_r,   arvalid_nxt_s;
    logic                    bready_r,    bready_nxt_s;
    logic                    rready_r,    rready_nxt_s;
    logic [ADDR_WIDTH-1:0]   awaddr_r,    awaddr_nxt_s;
    logic [ADDR_WIDTH-1:0]   araddr_r,    araddr_nxt_s;
    logic [DATA_WIDTH-1:0]   wdata_r,     wdata_nxt_s;
    logic [SW-1:0]           wstrb_r,     wstrb_nxt_s;
    logic                    rsp_valid_r, rsp_valid_nxt_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r, rsp_rdata_nxt_s;
    logic [1:0]              rsp_resp_r,  rsp_resp_nxt_s;

    logic aw_hs_s;
    logic w_hs_s;
    logic ar_hs_s;
    logic b_hs_s;
    logic r_hs_s;

    assign aw_hs_s = awvalid_r & m_axi_awready;
    assign w_hs_s  = wvalid_r  & m_axi_wready;
    assign ar_hs_s = arvalid_r & m_axi_arready;
    assign b_hs_s  = bready_r  & m_axi_bvalid;
    assign r_hs_s  = rready_r  & m_axi_rvalid;

`ifdef AXIL_CMD_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             in_wait_s;
    logic             tmo_hit_s;
    // wr_out/rd_out: an AXI transaction still owes us its B/R beat
    logic             wr_out_r, wr_out_nxt_s;
    logic             rd_out_r, rd_out_nxt_s;
    logic             rsp_timeout_r, rsp_timeout_nxt_s;

    assign in_wait_s = (state_r == WR) || (state_r == WR_RESP) ||
                       (state_r == RD_ADDR) || (state_r == RD_DATA);
    assign tmo_hit_s = in_wait_s && (cnt_r == TMO_LAST);

    // Watchdog count: restarts on every state change, advances only while waiting on the slave.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (in_wait_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end
`endif

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        state_nxt_s     = state_r;
        // a valid stays up until its own handshake, independently of the others
        awvalid_nxt_s   = awvalid_r & ~aw_hs_s;
        wvalid_nxt_s    = wvalid_r  & ~w_hs_s;
        arvalid_nxt_s   = arvalid_r & ~ar_hs_s;
        bready_nxt_s    = 1'b0;
        rready_nxt_s    = 1'b0;
        awaddr_nxt_s    = awaddr_r;
        araddr_nxt_s    = araddr_r;
        wdata_nxt_s     = wdata_r;
        wstrb_nxt_s     = wstrb_r;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_resp_nxt_s  = rsp_resp_r;
`ifdef AXIL_CMD_TIMEOUT_EN
        rsp_timeout_nxt_s = rsp_timeout_r;
        wr_out_nxt_s      = wr_out_r & ~b_hs_s;
        rd_out_nxt_s      = rd_out_r & ~r_hs_s;
`endif

        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_we) begin
                        awaddr_nxt_s  = cmd_addr;
                        wdata_nxt_s   = cmd_wdata;
                        wstrb_nxt_s   = cmd_wstrb;
                        awvalid_nxt_s = 1'b1;
                        wvalid_nxt_s  = 1'b1;
                        state_nxt_s   = WR;
`ifdef AXIL_CMD_TIMEOUT_EN
                        wr_out_nxt_s  = 1'b1;
`endif
                    end else begin
                        araddr_nxt_s  = cmd_addr;
                        arvalid_nxt_s = 1'b1;
                        state_nxt_s   = RD_ADDR;
`ifdef AXIL_CMD_TIMEOUT_EN
                        rd_out_nxt_s  = 1'b1;
`endif
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            WR: begin
                if (!awvalid_nxt_s && !wvalid_nxt_s) begin
                    bready_nxt_s = 1'b1;
                    state_nxt_s  = WR_RESP;
`ifdef AXIL_CMD_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    rsp_valid_nxt_s   = 1'b1;
                    rsp_rdata_nxt_s   = {DATA_WIDTH{1'b0}};
                    rsp_resp_nxt_s    = RESP_SLVERR;
                    rsp_timeout_nxt_s = 1'b1;
                    state_nxt_s       = RSP;
`endif
                end else begin
                    state_nxt_s = WR;
                end
            end

            WR_RESP: begin
                if (b_hs_s) begin
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rdata_nxt_s = {DATA_WIDTH{1'b0}};
                    rsp_resp_nxt_s  = m_axi_bresp;
                    state_nxt_s     = RSP;
`ifdef AXIL_CMD_TIMEOUT_EN
                    rsp_timeout_nxt_s = 1'b0;
                end else if (tmo_hit_s) begin
                    rsp_valid_nxt_s   = 1'b1;
                    rsp_rdata_nxt_s   = {DATA_WIDTH{1'b0}};
                    rsp_resp_nxt_s    = RESP_SLVERR;
                    rsp_timeout_nxt_s = 1'b1;
                    state_nxt_s       = RSP;
`endif
                end else begin
                    bready_nxt_s = 1'b1;
                    state_nxt_s  = WR_RESP;
                end
            end

            RD_ADDR: begin
                if (ar_hs_s) begin
                    rready_nxt_s = 1'b1;
                    state_nxt_s  = RD_DATA;
`ifdef AXIL_CMD_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    rsp_valid_nxt_s   = 1'b1;
                    rsp_rdata_nxt_s   = {DATA_WIDTH{1'b0}};
                    rsp_resp_nxt_s    = RESP_SLVERR;
                    rsp_timeout_nxt_s = 1'b1;
                    state_nxt_s       = RSP;
`endif
                end else begin
                    state_nxt_s = RD_ADDR;
                end
            end

            RD_DATA: begin
                if (r_hs_s) begin
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rdata_nxt_s = m_axi_rdata;
                    rsp_resp_nxt_s  = m_axi_rresp;
                    state_nxt_s     = RSP;
`ifdef AXIL_CMD_TIMEOUT_EN
                    rsp_timeout_nxt_s = 1'b0;
                end else if (tmo_hit_s) begin
                    rsp_valid_nxt_s   = 1'b1;
                    rsp_rdata_nxt_s   = {DATA_WIDTH{1'b0}};
                    rsp_resp_nxt_s    = RESP_SLVERR;
                    rsp_timeout_nxt_s = 1'b1;
                    state_nxt_s       = RSP;
`endif
                end else begin
                    rready_nxt_s = 1'b1;
                    state_nxt_s  = RD_DATA;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
`ifdef AXIL_CMD_TIMEOUT_EN
                    // a timed-out transaction is still live on AXI: finish it first
                    if (wr_out_nxt_s || rd_out_nxt_s) begin
                        bready_nxt_s = wr_out_nxt_s;
                        rready_nxt_s = rd_out_nxt_s;
                        state_nxt_s  = DRAIN;
                    end else begin
                        state_nxt_s  = IDLE;
                    end
`else
                    state_nxt_s = IDLE;
`endif
                end else begin
                    state_nxt_s = RSP;
                end
            end

`ifdef AXIL_CMD_TIMEOUT_EN
            DRAIN: begin
                // late B/R beats are accepted and discarded
                if (!wr_out_nxt_s && !rd_out_nxt_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    bready_nxt_s = wr_out_nxt_s;
                    rready_nxt_s = rd_out_nxt_s;
                    state_nxt_s  = DRAIN;
                end
            end
`endif

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; async reset abandons any in-flight transaction.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r     <= IDLE;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            awaddr_r    <= {ADDR_WIDTH{1'b0}};
            araddr_r    <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            wstrb_r     <= {SW{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_resp_r  <= RESP_OKAY;
`ifdef AXIL_CMD_TIMEOUT_EN
            cnt_r         <= {CNT_W{1'b0}};
            wr_out_r      <= 1'b0;
            rd_out_r      <= 1'b0;
            rsp_timeout_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            awvalid_r   <= awvalid_nxt_s;
            wvalid_r    <= wvalid_nxt_s;
            arvalid_r   <= arvalid_nxt_s;
            bready_r    <= bready_nxt_s;
            rready_r    <= rready_nxt_s;
            awaddr_r    <= awaddr_nxt_s;
            araddr_r    <= araddr_nxt_s;
            wdata_r     <= wdata_nxt_s;
            wstrb_r     <= wstrb_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_resp_r  <= rsp_resp_nxt_s;
`ifdef AXIL_CMD_TIMEOUT_EN
            cnt_r         <= cnt_nxt_s;
            wr_out_r      <= wr_out_nxt_s;
            rd_out_r      <= rd_out_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
`endif
        end
    end

    assign cmd_ready     = (state_r == IDLE);
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;
`ifdef AXIL_CMD_TIMEOUT_EN
    assign rsp_timeout   = rsp_timeout_r;
`else
    assign rsp_timeout   = 1'b0;
`endif
    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = wstrb_r;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_axil_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axil_cmd_master
// Directed bench for axil_cmd_master. The AXI slave side is driven by hand,
// cycle by cycle, and every expected value is a hand-computed constant.
// Cycle 0 is the cycle in which the command handshake takes place.
// ---------------------------------------------------------------------------
module tb_axil_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            aclk;
    logic            areset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_timeout;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    int tests_run    = 0;
    int tests_failed = 0;

    axil_cmd_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue_cmd(input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        check_val("cmd_ready_c0", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        areset    = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        awready   = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready   = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;

        // ---------------- reset state ----------------
        repeat (3) @(posedge aclk);
        #1;
        check_val("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check_val("rst_valids", {60'd0, awvalid, wvalid, arvalid, rsp_valid}, 64'd0);
        check_val("rst_readies", {62'd0, bready, rready}, 64'd0);
        check_val("rst_prot", {58'd0, awprot, arprot}, 64'd0);
        areset = 1'b0;
        tick();

        // ---------------- T1: best-case write ----------------
        awready = 1'b1; wready = 1'b1;
        issue_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        // cycle 1
        check_val("t1_c1_awvalid", {63'd0, awvalid}, 64'd1);
        check_val("t1_c1_wvalid", {63'd0, wvalid}, 64'd1);
        check_val("t1_c1_awaddr", {32'd0, awaddr}, 64'h10);
        check_val("t1_c1_wdata", {32'd0, wdata}, 64'hDEAD_BEEF);
        check_val("t1_c1_wstrb", {60'd0, wstrb}, 64'hF);
        check_val("t1_c1_bready", {63'd0, bready}, 64'd0);
        check_val("t1_c1_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        tick();
        // cycle 2
        awready = 1'b0; wready = 1'b0;
        check_val("t1_c2_valids", {62'd0, awvalid, wvalid}, 64'd0);
        check_val("t1_c2_bready", {63'd0, bready}, 64'd1);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        // cycle 3
        bvalid = 1'b0;
        check_val("t1_c3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("t1_c3_rsp_resp", {62'd0, rsp_resp}, 64'd0);
        check_val("t1_c3_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check_val("t1_c3_bready", {63'd0, bready}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("t1_c4_rsp_valid", {63'd0, rsp_valid}, 64'd0);

        // ---------------- T2: best-case read, back-to-back ----------------
        arready = 1'b1;
        issue_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        check_val("t2_c1_arvalid", {63'd0, arvalid}, 64'd1);
        check_val("t2_c1_araddr", {32'd0, araddr}, 64'h10);
        check_val("t2_c1_rready", {63'd0, rready}, 64'd0);
        check_val("t2_c1_awvalid", {63'd0, awvalid}, 64'd0);
        tick();
        arready = 1'b0;
        check_val("t2_c2_arvalid", {63'd0, arvalid}, 64'd0);
        check_val("t2_c2_rready", {63'd0, rready}, 64'd1);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        check_val("t2_c3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("t2_c3_rsp_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
        check_val("t2_c3_rsp_resp", {62'd0, rsp_resp}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---------------- T3: wready at once, awready late ----------------
        wready = 1'b1;
        issue_cmd(1'b1, 32'h0000_0024, 32'h0BAD_F00D, 4'h3);
        check_val("t3_c1_valids", {62'd0, awvalid, wvalid}, 64'd3);
        tick();
        wready = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            check_val($sformatf("t3_c%0d_wvalid", c), {63'd0, wvalid}, 64'd0);
            check_val($sformatf("t3_c%0d_awvalid", c), {63'd0, awvalid}, 64'd1);
            check_val($sformatf("t3_c%0d_awaddr", c), {32'd0, awaddr}, 64'h24);
            check_val($sformatf("t3_c%0d_bready", c), {63'd0, bready}, 64'd0);
            if (c == 5) begin
                awready = 1'b1;
            end
            tick();
        end
        // cycle 6
        awready = 1'b0;
        check_val("t3_c6_awvalid", {63'd0, awvalid}, 64'd0);
        check_val("t3_c6_bready", {63'd0, bready}, 64'd1);
        bvalid = 1'b1; bresp = 2'b01;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        check_val("t3_c7_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("t3_c7_rsp_resp", {62'd0, rsp_resp}, 64'd1);
        check_val("t3_c7_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---------------- T4: DECERR read, response back-pressured ----------------
        arready = 1'b1;
        issue_cmd(1'b0, 32'h0000_0103, 32'h0, 4'h0);
        check_val("t4_c1_araddr_unaligned", {32'd0, araddr}, 64'h103);
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b11;
        tick();
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        for (int c = 0; c < 4; c++) begin
            check_val($sformatf("t4_hold%0d_rsp_valid", c), {63'd0, rsp_valid}, 64'd1);
            check_val($sformatf("t4_hold%0d_rsp_rdata", c), {32'd0, rsp_rdata}, 64'h1234_5678);
            check_val($sformatf("t4_hold%0d_rsp_resp", c), {62'd0, rsp_resp}, 64'd3);
            check_val($sformatf("t4_hold%0d_cmd_ready", c), {63'd0, cmd_ready}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("t4_done_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("t4_done_cmd_ready", {63'd0, cmd_ready}, 64'd1);

`ifdef AXIL_CMD_TIMEOUT_EN
        // ---------------- T5: watchdog on a stuck AR, then drain ----------------
        issue_cmd(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        for (int c = 1; c <= 8; c++) begin
            check_val($sformatf("t5_c%0d_rsp_valid", c), {63'd0, rsp_valid}, 64'd0);
            check_val($sformatf("t5_c%0d_arvalid", c), {63'd0, arvalid}, 64'd1);
            tick();
        end
        // cycle 9
        check_val("t5_c9_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("t5_c9_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
        check_val("t5_c9_rsp_resp", {62'd0, rsp_resp}, 64'd2);
        check_val("t5_c9_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check_val("t5_c9_arvalid", {63'd0, arvalid}, 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // cycle 10: draining, AR still pending
        check_val("t5_c10_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_val("t5_c10_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check_val("t5_c10_arvalid", {63'd0, arvalid}, 64'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check_val("t5_c11_arvalid", {63'd0, arvalid}, 64'd0);
        check_val("t5_c11_rready", {63'd0, rready}, 64'd1);
        rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        check_val("t5_c12_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check_val("t5_c12_rready", {63'd0, rready}, 64'd0);
        check_val("t5_c12_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        // next command is accepted and completes normally
        awready = 1'b1; wready = 1'b1;
        issue_cmd(1'b1, 32'h0000_0300, 32'h0000_00AA, 4'h1);
        tick();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check_val("t5_next_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("t5_next_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        check_val("t5_next_rsp_resp", {62'd0, rsp_resp}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`else
        check_val("no_watchdog_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
`endif

        // ---------------- T6: asynchronous reset while in WR_RESP ----------------
        // leave a non-zero response behind so the reset clearing it is visible
        arready = 1'b1;
        issue_cmd(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h5555_AAAA; rresp = 2'b11;
        tick();
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        awready = 1'b1; wready = 1'b1;
        issue_cmd(1'b1, 32'h0000_0040, 32'h1357_9BDF, 4'hC);
        tick();
        awready = 1'b0; wready = 1'b0;
        check_val("t6_pre_bready", {63'd0, bready}, 64'd1);
        check_val("t6_pre_awaddr", {32'd0, awaddr}, 64'h40);
        areset = 1'b1;
        #1;
        check_val("t6_async_bready", {63'd0, bready}, 64'd0);
        check_val("t6_async_awaddr", {32'd0, awaddr}, 64'd0);
        check_val("t6_async_araddr", {32'd0, araddr}, 64'd0);
        check_val("t6_async_wdata", {32'd0, wdata}, 64'd0);
        check_val("t6_async_wstrb", {60'd0, wstrb}, 64'd0);
        check_val("t6_async_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check_val("t6_async_rsp_resp", {62'd0, rsp_resp}, 64'd0);
        check_val("t6_async_valids", {59'd0, awvalid, wvalid, arvalid, rsp_valid, rsp_timeout}, 64'd0);
        check_val("t6_async_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        #2;
        areset = 1'b0;
        tick();
        check_val("t6_after_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check_val("t6_after_bready", {63'd0, bready}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
